// File: rtl/dec_ram_pkg.sv
// Shared types and helpers for the LDPC decision RAM: FSM encoding,
// bank-index width and ring-pointer arithmetic.
package dec_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Bank index width, never narrower than one bit.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Modular increment around the bank ring.
  function automatic int next_bank(input int bank, input int num_banks);
    return (bank == num_banks - 1) ? 0 : bank + 1;
  endfunction

endpackage

// File: rtl/dec_ram_bank.sv
// One decision-RAM bank: simple synchronous 1W/1R array with a registered
// read port that holds its value between reads.
module dec_ram_bank #(
  parameter int DATA_WIDTH = 1,
  parameter int RAM_DEPTH  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // read register is reset. Sequential state uses <= so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dec_pingpong_ram.sv
// Multi-bank decision RAM: one bank fills while another drains, banks rotate
// on a swap handshake, and a sequencer can zero the fill bank.
module dec_pingpong_ram
  import dec_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int NUM_BANKS  = 2,
  localparam int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  swap_req,
  output logic                  swap_ack,
  input  logic                  clr_req,
  output logic                  clr_done,
  output logic                  busy,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [BANK_W-1:0]     rd_bank
);

  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [IDX_W-1:0]    CLR_LAST = IDX_W'(RAM_DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_clr_cnt;
  logic [BANK_W-1:0]     r_wr_bank, r_rd_bank, r_rd_sel;
  logic                  r_rd_valid, r_rd_oor, r_swap_ack, r_clr_done;

  logic                  w_wr_in_rng, w_rd_in_rng, w_rd_fire;
  logic                  w_wr_fire, w_swap_fire, w_clr_start, w_clr_active, w_clr_last;
  logic [IDX_W-1:0]      w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

  assign w_wr_in_rng = ({1'b0, wr_addr} < DEPTH_C);
  assign w_rd_in_rng = ({1'b0, rd_addr} < DEPTH_C);
  assign w_rd_fire   = cs & rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cs && clr_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last)    w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clr_active = (r_state == ST_CLEAR);
    w_clr_last   = w_clr_active && (r_clr_cnt == CLR_LAST);
    w_clr_start  = (r_state == ST_IDLE) && cs && clr_req;
    w_wr_fire    = (r_state == ST_IDLE) && cs && wr_en && w_wr_in_rng;
    w_swap_fire  = (r_state == ST_IDLE) && cs && swap_req && !clr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= w_clr_last;
      if (w_clr_start)       r_clr_cnt <= '0;
      else if (w_clr_active) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Both pointers advance together so the read bank always trails the fill bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= '0;
      r_rd_bank  <= BANK_W'(NUM_BANKS - 1);
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= w_swap_fire;
      if (w_swap_fire) begin
        r_wr_bank <= BANK_W'(next_bank(int'(r_wr_bank), NUM_BANKS));
        r_rd_bank <= BANK_W'(next_bank(int'(r_rd_bank), NUM_BANKS));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_rd_sel   <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_oor <= !w_rd_in_rng;
        r_rd_sel <= r_rd_bank;
      end
    end
  end

  // The clear sequencer borrows the write port of the fill bank.
  assign w_waddr = w_clr_active ? r_clr_cnt : wr_addr[IDX_W-1:0];
  assign w_wdata = w_clr_active ? '0 : wr_data;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dec_ram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .IDX_W     (IDX_W)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   ((r_wr_bank == BANK_W'(b)) && (w_wr_fire || w_clr_active)),
      .i_waddr(w_waddr),
      .i_wdata(w_wdata),
      .i_re   (w_rd_fire && w_rd_in_rng && (r_rd_bank == BANK_W'(b))),
      .i_raddr(rd_addr[IDX_W-1:0]),
      .o_rdata(w_bank_rdata[b])
    );
  end

  assign rd_data  = r_rd_oor ? '0 : w_bank_rdata[r_rd_sel];
  assign rd_valid = r_rd_valid;
  assign swap_ack = r_swap_ack;
  assign clr_done = r_clr_done;
  assign busy     = (r_state == ST_CLEAR);
  assign wr_bank  = r_wr_bank;
  assign rd_bank  = r_rd_bank;

endmodule

// File: tb/tb_dec_pingpong_ram.sv
// Directed bench for dec_pingpong_ram (4 banks x 256 x 8 bit, 9-bit address);
// read responses are checked by a scoreboard monitor.
module tb_dec_pingpong_ram;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int DEPTH = 256;
  localparam int NB = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs, wr_en, rd_en, swap_req, clr_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, swap_ack, clr_done, busy;
  logic [BW-1:0] wr_bank, rd_bank;

  typedef struct {
    logic [DW-1:0] data;
    bit            chk;
  } sb_item_t;

  sb_item_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  dec_pingpong_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .wr_bank(wr_bank), .rd_bank(rd_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid pops one expected read response.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
      end else begin
        sb_item_t it;
        it = sb.pop_front();
        if (it.chk) check("rd_data", 32'(rd_data), 32'(it.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [DW-1:0] exp, input bit chk);
    sb_item_t it;
    it.data = exp;
    it.chk  = chk;
    rd_en = 1'b1; rd_addr = AW'(addr);
    sb.push_back(it);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic swap_once(input int exp_wr);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap_ack_pulse", 32'(swap_ack), 32'd1);
    check("wr_bank_after_swap", 32'(wr_bank), 32'(exp_wr));
    check("rd_bank_after_swap", 32'(rd_bank), 32'((exp_wr + NB - 1) % NB));
    tick();
    check("swap_ack_drop", 32'(swap_ack), 32'd0);
  endtask

  initial begin
    int busy_cnt, guard;
    bit ack_in_clr, done_in_clr;

    rst_n = 1'b0; cs = 1'b1; wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0; clr_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    #12;
    check("rst_wr_bank", 32'(wr_bank), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd3);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_done", {30'd0, swap_ack, clr_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    rd(0, 8'h00, 1'b0);
    check("first_rd_valid", 32'(rd_valid), 32'd1);
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);

    // Fill bank 0 with its address, rotate, read back.
    for (int i = 0; i < DEPTH; i++) wr(i, DW'(i));
    swap_once(1);
    rd(16'h5A, 8'h5A, 1'b1);
    check("rd_latency", 32'(rd_valid), 32'd1);
    rd(0, 8'h00, 1'b1);
    rd(255, 8'hFF, 1'b1);
    tick();
    check("hold_rd_valid", 32'(rd_valid), 32'd0);
    check("hold_rd_data", 32'(rd_data), 32'hFF);

    // Write and read in the swap-accept cycle use the pre-swap banks.
    begin
      sb_item_t it;
      it.data = 8'h10; it.chk = 1'b1;
      sb.push_back(it);
    end
    wr_en = 1'b1; wr_addr = 9'd7; wr_data = 8'hFF;
    rd_en = 1'b1; rd_addr = 9'h10; swap_req = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0;
    check("swap_wr_ack", 32'(swap_ack), 32'd1);
    check("swap_wr_bank", 32'(wr_bank), 32'd2);
    tick();
    rd(7, 8'hFF, 1'b1);

    // Clear and swap requested together: clear wins, swap follows clr_done.
    for (int i = 0; i < DEPTH; i++) wr(i, ~DW'(i));
    clr_req = 1'b1; swap_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = busy ? 1 : 0;
    guard = 0; ack_in_clr = 1'b0; done_in_clr = 1'b0;
    while (busy && guard < 400) begin
      if (swap_ack) ack_in_clr = 1'b1;
      if (clr_done) done_in_clr = 1'b1;
      if (busy_cnt == 50) begin
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 9'd3; wr_data = 8'h55;
      end else begin
        clr_req = 1'b0; wr_en = 1'b0;
      end
      tick();
      guard++;
      if (busy) busy_cnt++;
    end
    clr_req = 1'b0; wr_en = 1'b0;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd256);
    check("clr_no_swap_ack", 32'(ack_in_clr), 32'd0);
    check("clr_no_early_done", 32'(done_in_clr), 32'd0);
    check("clr_done_pulse", 32'(clr_done), 32'd1);
    check("clr_swap_waits", 32'(swap_ack), 32'd0);
    tick();
    swap_req = 1'b0;
    check("clr_then_swap_ack", 32'(swap_ack), 32'd1);
    check("clr_then_rd_bank", 32'(rd_bank), 32'd2);
    check("clr_done_drop", 32'(clr_done), 32'd0);
    for (int i = 0; i < DEPTH; i++) rd(i, 8'h00, 1'b1);
    repeat (2) tick();

    // Reset in the middle of a clear of bank 3.
    for (int i = 0; i < DEPTH; i++) wr(i, DW'(i) ^ 8'hA5);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #2;
    check("midclr_busy_async", 32'(busy), 32'd0);
    check("midclr_no_done", 32'(clr_done), 32'd0);
    check("midclr_rd_bank", 32'(rd_bank), 32'd3);
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("midclr_no_done_after", 32'(clr_done), 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) rd(i, (i < 100) ? 8'h00 : (DW'(i) ^ 8'hA5), 1'b1);
    repeat (2) tick();

    // Out-of-range address and cs gating on bank 0.
    wr(300, 8'h77);
    cs = 1'b0; wr_en = 1'b1; wr_addr = 9'd45; wr_data = 8'h99;
    rd_en = 1'b1; rd_addr = 9'd45; swap_req = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0; cs = 1'b1;
    check("cs_no_swap", 32'(swap_ack), 32'd0);
    check("cs_no_rd_valid", 32'(rd_valid), 32'd0);
    swap_once(1);
    rd(44, 8'd44, 1'b1);
    rd(45, 8'd45, 1'b1);
    rd(300, 8'h00, 1'b1);
    check("oor_rd_valid", 32'(rd_valid), 32'd1);
    tick();
    check("oor_hold_data", 32'(rd_data), 32'd0);

    // Held swap_req rotates once per cycle and wraps the ring.
    swap_req = 1'b1;
    tick();
    check("hold_swap_wr2", 32'(wr_bank), 32'd2);
    tick();
    check("hold_swap_wr3", 32'(wr_bank), 32'd3);
    tick();
    swap_req = 1'b0;
    check("wrap_wr_bank", 32'(wr_bank), 32'd0);
    check("wrap_rd_bank", 32'(rd_bank), 32'd3);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_pingpong_ram.md
Name: dec_pingpong_ram

Overview:
- Multi-bank decision RAM for the LDPC decoder, replacing the fixed two-bank, single-port decision store.
- The write side fills one bank while the read side drains a different bank, so decoder iterations overlap with hard-decision readout.
- Banks rotate under a swap handshake.
- A built-in clear sequencer zeroes the fill bank before a new codeword is written.

Parameters:
- DATA_WIDTH, 1, bits per word
- ADDR_WIDTH, 8, address bits per bank
- RAM_DEPTH, 256, words per bank (must be <= 2**ADDR_WIDTH)
- NUM_BANKS, 2, number of banks in the rotation ring (must be >= 2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select; gates wr_en, rd_en, swap_req and clr_req
- wr_en  in  1  write strobe into the fill bank
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe from the read bank
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data is valid this cycle
- swap_req  in  1  level request to rotate the banks
- swap_ack  out  1  one-cycle pulse: rotation taken at this edge
- clr_req  in  1  start zeroing the fill bank
- clr_done  out  1  one-cycle pulse: clear finished
- busy  out  1  clear sequence in progress
- wr_bank  out  clog2(NUM_BANKS)  current fill bank index
- rd_bank  out  clog2(NUM_BANKS)  current read bank index

Behaviour:
- Reset (async, rst_n=0):
  - wr_bank=0, rd_bank=NUM_BANKS-1.
  - rd_data=0, rd_valid=0, swap_ack=0, clr_done=0, busy=0.
  - FSM=IDLE, clear counter=0.
  - Memory contents are not reset.
- Bank pointers:
  - rd_bank is always (wr_bank+NUM_BANKS-1) mod NUM_BANKS, so the write and read banks never coincide.
- Write:
  - When cs&wr_en&(state==IDLE)&(wr_addr<RAM_DEPTH), mem[wr_bank][wr_addr] is written at the edge.
  - An out-of-range address is dropped silently.
- Read:
  - When cs&rd_en, rd_data <= mem[rd_bank][rd_addr] at the edge and rd_valid=1 for that following cycle. Latency is 1.
  - When cs&rd_en is false, rd_valid=0 and rd_data holds its last value.
  - An out-of-range rd_addr returns 0 with rd_valid=1.
  - Reads are allowed in every FSM state.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on cs&clr_req. Counter<=0, busy<=1.
  - CLEAR: each cycle mem[wr_bank][counter]<=0, then counter++.
  - When counter==RAM_DEPTH-1 the last zero is written, FSM returns to IDLE, busy<=0, and clr_done pulses in the first IDLE cycle.
  - A clear therefore takes exactly RAM_DEPTH cycles with busy high.
- Swap:
  - Accepted at an edge where state==IDLE & cs & swap_req & !clr_req.
  - At that edge wr_bank <= (wr_bank+1) mod NUM_BANKS, rd_bank follows, and swap_ack pulses for the next cycle.
  - A held swap_req produces one rotation per cycle. The requester must drop swap_req on seeing swap_ack.
- Simultaneous events:
  - A write or read in the swap-accept cycle uses the pre-swap banks.
  - If clr_req and swap_req arrive together, clear wins and the swap waits until IDLE.
  - During CLEAR, wr_en is ignored and swap_req is not acknowledged.
  - clr_req during CLEAR is ignored; it does not restart the sequence.
- Reset mid-clear: the FSM returns to IDLE immediately, the bank is left partially cleared, and clr_done is not pulsed.

Decomposition:
- Package dec_ram_pkg holds:
  - the FSM state enum (IDLE, CLEAR)
  - a BANK_W = clog2(NUM_BANKS) helper
  - a next_bank function (modular increment)
- Natural sub-module: dec_ram_bank, one simple synchronous 1W/1R array of RAM_DEPTH x DATA_WIDTH, instantiated NUM_BANKS times via generate.
- The top level holds the pointers, FSM, clear counter and output muxing.

Test Plan:
- Reset, then read bank 3 (NUM_BANKS=4, DATA_WIDTH=8) -> wr_bank=0, rd_bank=3, rd_valid=0 until the first rd_en.
- Write mem[0][i]=i for i=0..255, pulse swap_req -> swap_ack one cycle later, rd_bank=0; reading addr 0x5A returns 0x5A with rd_valid one cycle after rd_en.
- Assert clr_req and swap_req in the same cycle -> busy high for exactly 256 cycles, swap_ack only after clr_done; the cleared bank reads 0 at all addresses after rotation.
- Write 0xFF to addr 7 in the swap-accept cycle -> the data lands in the old fill bank and is readable after the next rotation.
- Drop rst_n at clear count 100 -> busy=0 asynchronously, no clr_done; addresses 0..99 read 0 and 100..255 keep old data.
- Access addr 300 with ADDR_WIDTH=9, RAM_DEPTH=256 -> the write is dropped and the read returns 0 with rd_valid=1.
